// File: rtl/fir_dec_sched_pkg.sv
// Shared types and constants for the decimating-FIR sequencer.
// FSM encoding, overrun-counter width and a saturating increment helper.
package fir_dec_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OVR_CNT_W = 16;

    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (v == {OVR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fir_dec_sched_mod_counter.sv
// Enabled modulo-MOD counter; wrap flags the enabled cycle that returns cnt to zero.
module fir_dec_sched_mod_counter #(
    parameter int MOD = 2,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    assign wrap = en && (cnt == W'(MOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/fir_dec_sched.sv
// Single-MAC decimating FIR sequencer: ring write pointer, decimation count, MAC stepping.
// Optional FIR_DEC_SCHED_OVR_CNT_EN adds a saturating ovr_cnt port counting dropped launches.
module fir_dec_sched
    import fir_dec_sched_pkg::*;
#(
    parameter int TAPS  = 32,
    parameter int DECIM = 40,
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int CAW   = 5
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           smp_stb,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [AW-1:0]  rd_addr,
    output logic [CAW-1:0] coef_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           out_stb,
    output logic           busy,
    output logic           ovr
`ifdef FIR_DEC_SCHED_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CAW:0] K_LAST = (CAW + 1)'(TAPS - 1);

    state_t        state, state_nxt;
    logic [DW-1:0] dcnt;
    logic          launch;
    logic          ptr_wrap;
    logic          unused_sigs;
    logic [CAW:0]  k, k_nxt;
    logic [AW-1:0] base;
    logic          k_last;

    assign wr_en       = smp_stb;
    assign unused_sigs = ^{dcnt, ptr_wrap};
    assign k_nxt       = k + 1'b1;
    assign k_last      = (k == K_LAST);

    fir_dec_sched_mod_counter #(.MOD(DEPTH), .W(AW)) u_ptr (
        .clk  (clk),
        .rst  (rst),
        .en   (smp_stb),
        .cnt  (wr_addr),
        .wrap (ptr_wrap)
    );

    fir_dec_sched_mod_counter #(.MOD(DECIM), .W(DW)) u_dcnt (
        .clk  (clk),
        .rst  (rst),
        .en   (smp_stb),
        .cnt  (dcnt),
        .wrap (launch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        out_stb   = (state == DONE);
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (k_last) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are registered one step ahead so they present base-k while k is current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            base      <= '0;
            rd_addr   <= '0;
            coef_addr <= '0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            mac_en  <= (state == RUN);
            mac_clr <= (state == RUN) && (k == '0);
            if (launch) begin
                if (state == IDLE) begin
                    base      <= wr_addr;
                    k         <= '0;
                    rd_addr   <= wr_addr;
                    coef_addr <= '0;
                end else begin
                    ovr <= 1'b1;
                end
            end
            if (state == RUN) begin
                k <= k_nxt;
                if (!k_last) begin
                    rd_addr   <= base - AW'(k_nxt);
                    coef_addr <= k_nxt[CAW-1:0];
                end
            end
        end
    end

`ifdef FIR_DEC_SCHED_OVR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_cnt <= '0;
        else if (launch && (state != IDLE))
            ovr_cnt <= sat_inc(ovr_cnt);
    end
`else
    // Overruns are reported only through the sticky ovr flag in this build.
`endif

endmodule

// File: tb/tb_fir_dec_sched.sv
// Randomized bench for fir_dec_sched: a default instance and a small overrun-prone instance,
// both checked every cycle against a launch-age schedule model.
module tb_fir_dec_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic smp_stb = 1'b0;

    always #5 clk = ~clk;

    logic       a_wr_en, a_mac_clr, a_mac_en, a_out_stb, a_busy, a_ovr;
    logic [6:0] a_wr_addr, a_rd_addr;
    logic [4:0] a_coef_addr;
    logic       b_wr_en, b_mac_clr, b_mac_en, b_out_stb, b_busy, b_ovr;
    logic [5:0] b_wr_addr, b_rd_addr;
    logic [4:0] b_coef_addr;
`ifdef FIR_DEC_SCHED_OVR_CNT_EN
    logic [15:0] a_ovr_cnt, b_ovr_cnt;
`endif

    fir_dec_sched #(.TAPS(32), .DECIM(40), .DEPTH(128), .AW(7), .CAW(5)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .smp_stb   (smp_stb),
        .wr_en     (a_wr_en),
        .wr_addr   (a_wr_addr),
        .rd_addr   (a_rd_addr),
        .coef_addr (a_coef_addr),
        .mac_clr   (a_mac_clr),
        .mac_en    (a_mac_en),
        .out_stb   (a_out_stb),
        .busy      (a_busy),
        .ovr       (a_ovr)
`ifdef FIR_DEC_SCHED_OVR_CNT_EN
        ,
        .ovr_cnt   (a_ovr_cnt)
`endif
    );

    fir_dec_sched #(.TAPS(32), .DECIM(16), .DEPTH(64), .AW(6), .CAW(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .smp_stb   (smp_stb),
        .wr_en     (b_wr_en),
        .wr_addr   (b_wr_addr),
        .rd_addr   (b_rd_addr),
        .coef_addr (b_coef_addr),
        .mac_clr   (b_mac_clr),
        .mac_en    (b_mac_en),
        .out_stb   (b_out_stb),
        .busy      (b_busy),
        .ovr       (b_ovr)
`ifdef FIR_DEC_SCHED_OVR_CNT_EN
        ,
        .ovr_cnt   (b_ovr_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int phase = 0;

    int p_taps[2]  = '{32, 32};
    int p_decim[2] = '{40, 16};
    int p_depth[2] = '{128, 64};

    // age = cycles since the accepted launch edge (0 = idle); the whole schedule derives from it.
    int age[2], base[2], wr[2], dcnt[2], ovr[2], ocnt[2], lrd[2], lcoef[2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            age[i] = 0; base[i] = 0; wr[i] = 0; dcnt[i] = 0;
            ovr[i] = 0; ocnt[i] = 0; lrd[i] = 0; lcoef[i] = 0;
        end
    endtask

    task automatic modelStep(input logic stb);
        for (int i = 0; i < 2; i++) begin
            bit was_busy;
            was_busy = (age[i] != 0);
            if (was_busy)
                age[i] = (age[i] == p_taps[i] + 2) ? 0 : age[i] + 1;
            if (stb) begin
                if (dcnt[i] == p_decim[i] - 1) begin
                    dcnt[i] = 0;
                    if (!was_busy) begin
                        base[i] = wr[i];
                        age[i]  = 1;
                    end else begin
                        ovr[i] = 1;
                        if (ocnt[i] < 65535) ocnt[i]++;
                    end
                end else begin
                    dcnt[i]++;
                end
                wr[i] = (wr[i] + 1) % p_depth[i];
            end
        end
    endtask

    task automatic checkInst(input int i);
        logic [31:0] g_wr, g_rd, g_coef, g_clr, g_en, g_out, g_busy, g_ovr, g_wen;
        string p;
        int t;
        t = p_taps[i];
        p = (i == 0) ? "A." : "B.";
        if (age[i] >= 1 && age[i] <= t) begin
            lrd[i]   = (base[i] - (age[i] - 1) + p_depth[i]) % p_depth[i];
            lcoef[i] = age[i] - 1;
        end
        if (i == 0) begin
            g_wr = a_wr_addr; g_rd = a_rd_addr; g_coef = a_coef_addr; g_clr = a_mac_clr;
            g_en = a_mac_en; g_out = a_out_stb; g_busy = a_busy; g_ovr = a_ovr; g_wen = a_wr_en;
        end else begin
            g_wr = b_wr_addr; g_rd = b_rd_addr; g_coef = b_coef_addr; g_clr = b_mac_clr;
            g_en = b_mac_en; g_out = b_out_stb; g_busy = b_busy; g_ovr = b_ovr; g_wen = b_wr_en;
        end
        checkOutput({p, "wr_en"},     g_wen,  int'(smp_stb));
        checkOutput({p, "wr_addr"},   g_wr,   wr[i]);
        checkOutput({p, "rd_addr"},   g_rd,   lrd[i]);
        checkOutput({p, "coef_addr"}, g_coef, lcoef[i]);
        checkOutput({p, "mac_clr"},   g_clr,  int'(age[i] == 2));
        checkOutput({p, "mac_en"},    g_en,   int'(age[i] >= 2 && age[i] <= t + 1));
        checkOutput({p, "out_stb"},   g_out,  int'(age[i] == t + 2));
        checkOutput({p, "busy"},      g_busy, int'(age[i] != 0));
        checkOutput({p, "ovr"},       g_ovr,  ovr[i]);
`ifdef FIR_DEC_SCHED_OVR_CNT_EN
        checkOutput({p, "ovr_cnt"}, (i == 0) ? 32'(a_ovr_cnt) : 32'(b_ovr_cnt), ocnt[i]);
`endif
    endtask

    // period > 0: strobe every period-th cycle; period == 0: random strobe with pct% probability.
    task automatic applyStimulus(input logic r, input int n, input int period, input int pct);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst = r;
            if (period > 0)
                smp_stb = ((phase % period) == 0);
            else
                smp_stb = ($urandom_range(99) < pct);
            phase++;
            #1;
            if (r) modelReset();
            checkInst(0);
            checkInst(1);
            if (!r) modelStep(smp_stb);
        end
    endtask

    initial begin
        int guard;
        bit reached;
        modelReset();
        $display("[TB] reset with strobes");
        applyStimulus(1'b1, 6, 2, 0);

        $display("[TB] continuous strobes: first output, ring wrap, overrun on B");
        applyStimulus(1'b0, 400, 1, 0);
        checkOutput("B.ovr_after_burst", b_ovr, 1);
        checkOutput("A.ovr_after_burst", a_ovr, 0);

        $display("[TB] gated strobes every 3rd cycle");
        applyStimulus(1'b0, 300, 3, 0);

        $display("[TB] random strobes 50%%");
        applyStimulus(1'b0, 600, 0, 50);

        $display("[TB] reset mid-run");
        guard = 0;
        while (age[0] != 10 && guard < 300) begin
            applyStimulus(1'b0, 1, 1, 0);
            guard++;
        end
        reached = (age[0] == 10);
        checkOutput("midrun_reached", reached, 1);
        applyStimulus(1'b1, 2, 1, 0);
        applyStimulus(1'b0, 200, 1, 0);

        $display("[TB] random strobes 80%%");
        applyStimulus(1'b0, 500, 0, 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
